periph_bus: RTL and testbench

PERIPH_BUS -- requirements
Module: periph_bus

---
 rtl/periph_bus_pkg.sv | 33 +++
 rtl/periph_bus_timeout.sv | 52 +++++
 rtl/periph_bus.sv | 194 +++++++++++++++++++
 tb/tb_periph_bus.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_bus_pkg.sv
// -----------------------------------------------------------------------------
// periph_bus_pkg
// Shared definitions for the peripheral bus decoder: the access FSM state type,
// STATUS register bit positions, the internal status slot number and the
// register offsets inside that slot.
// -----------------------------------------------------------------------------
package periph_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ABORT  = 2'd2
    } bus_state_e;

    // STATUS register bit positions
    localparam int STAT_TIMEOUT_BIT  = 0;
    localparam int STAT_DECODE_BIT   = 1;
    localparam int STAT_OVERFLOW_BIT = 7;

    // Bits that software may clear by writing 1
    localparam logic [7:0] STATUS_W1C_MASK = 8'h83;

    // Address page that selects the register slots; every other page is memory
    localparam logic [7:0] SLOT_PAGE   = 8'hFF;
    localparam logic [3:0] STATUS_SLOT = 4'hF;

    // Register offsets inside the status slot
    localparam logic [3:0] REG_STATUS      = 4'h0;
    localparam logic [3:0] REG_ERR_ADDR_LO = 4'h1;
    localparam logic [3:0] REG_ERR_ADDR_HI = 4'h2;
    localparam logic [3:0] REG_NUM_SLOTS   = 4'h3;

endpackage

// File: rtl/periph_bus_timeout.sv
// -----------------------------------------------------------------------------
// bus_timeout
// Counts consecutive wait cycles of the current access and flags the cycle on
// which the access has to be aborted.
//   clk, rst_n  clock, asynchronous active-low reset
//   enable_i    access is subject to timeout in this cycle
//   wait_i      addressed target is stalling
//   done_i      access completes normally in this cycle
//   expire_o    this is the TIMEOUT_CYCLES-th consecutive wait cycle: abort
// -----------------------------------------------------------------------------
module bus_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    input  logic wait_i,
    input  logic done_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // count_q holds the wait cycles already elapsed, so the current cycle is
    // number count_q+1. A target that drops wait in that cycle is a normal
    // completion (done_i), which keeps expire low.
    assign expire_o = enable_i & wait_i & ~done_i
                    & (count_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: default assigned first so every path drives count_d; no latch.
        count_d = count_q;
        if (!enable_i || done_i || expire_o) begin
            count_d = '0;
        end else if (wait_i && (count_q != CW'(TIMEOUT_CYCLES))) begin
            count_d = count_q + 1'b1;  // saturates, never wraps
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            // NOTE: non-blocking for state so all flops update together at the edge.
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/periph_bus.sv
// -----------------------------------------------------------------------------
// periph_bus
// CPU bus decoder. Page 8'hFF goes to register slots selected by
// bus_address[7:4]; everything else goes to memory. Slot 4'hF is the internal
// status block, slots NUM_SLOTS..14 are unmapped. Stalled accesses are aborted
// after TIMEOUT_CYCLES consecutive wait cycles.
//   clk, rst_n              clock, asynchronous active-low reset
//   bus_*                   CPU side: address, write data, strobes, read data, wait
//   mem_*                   memory side: strobes, read data, wait
//   slot_address/data_tx    shared slot address and write data
//   slot_read/slot_write    one-hot slot strobes
//   slot_data_rx/slot_wait  per-slot read data (8 bits each) and stall
//   error_irq               registered, high while STATUS timeout/decode set
// -----------------------------------------------------------------------------
module periph_bus
    import periph_bus_pkg::*;
#(
    parameter int NUM_SLOTS      = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MEM_TIMEOUT_EN = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            bus_address,
    input  logic [7:0]             bus_data_tx,
    input  logic                   bus_read,
    input  logic                   bus_write,
    output logic [7:0]             bus_data_rx,
    output logic                   bus_wait,
    output logic                   mem_read,
    output logic                   mem_write,
    input  logic [7:0]             mem_data_rx,
    input  logic                   mem_wait,
    output logic [3:0]             slot_address,
    output logic [7:0]             slot_data_tx,
    output logic [NUM_SLOTS-1:0]   slot_read,
    output logic [NUM_SLOTS-1:0]   slot_write,
    input  logic [8*NUM_SLOTS-1:0] slot_data_rx,
    input  logic [NUM_SLOTS-1:0]   slot_wait,
    output logic                   error_irq
);

    bus_state_e  state_q, state_d;
    logic [7:0]  status_q, status_d;
    logic [15:0] err_addr_q, err_addr_d;
    logic        error_irq_q;

    // Error seen on the bus, applied to STATUS one cycle later. This lets an
    // error and a write-1-clear of STATUS meet in the same update cycle.
    logic        pend_valid_q;
    logic        pend_timeout_q;
    logic [15:0] pend_addr_q;

    logic [3:0] slot_idx;
    logic       strobe, in_abort;
    logic       is_slot_page, is_status, is_unmapped, is_ext_slot;
    logic       tgt_wait;
    logic [7:0] tgt_rdata, status_rdata, slot_rdata;
    logic       slot_wait_sel;
    logic       tmo_applicable, expire;
    logic       err_evt, status_clr;

    // ---------------------------------------------------------------- decode
    assign slot_idx     = bus_address[7:4];
    assign strobe       = bus_read | bus_write;
    assign in_abort     = (state_q == ST_ABORT);
    assign is_slot_page = (bus_address[15:8] == SLOT_PAGE);
    assign is_status    = is_slot_page & (slot_idx == STATUS_SLOT);
    assign is_unmapped  = is_slot_page & ~is_status & (int'(slot_idx) >= NUM_SLOTS);
    assign is_ext_slot  = is_slot_page & ~is_status & ~is_unmapped;

    assign slot_address = bus_address[3:0];
    assign slot_data_tx = bus_data_tx;

    always_comb begin
        case (bus_address[3:0])
            REG_STATUS:      status_rdata = status_q;
            REG_ERR_ADDR_LO: status_rdata = err_addr_q[7:0];
            REG_ERR_ADDR_HI: status_rdata = err_addr_q[15:8];
            REG_NUM_SLOTS:   status_rdata = 8'(NUM_SLOTS);
            default:         status_rdata = 8'h00;
        endcase
    end

    // Per-target read data, wait and one-hot strobes
    always_comb begin
        slot_rdata    = 8'hFF;
        slot_wait_sel = 1'b0;
        slot_read     = '0;
        slot_write    = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_idx == 4'(i)) begin
                slot_rdata    = slot_data_rx[8*i +: 8];
                slot_wait_sel = slot_wait[i];
                slot_read[i]  = bus_read  & is_ext_slot & ~in_abort;
                slot_write[i] = bus_write & is_ext_slot & ~in_abort;
            end
        end

        if (!is_slot_page) begin
            tgt_wait  = mem_wait;
            tgt_rdata = mem_data_rx;
        end else if (is_status) begin
            tgt_wait  = 1'b0;
            tgt_rdata = status_rdata;
        end else if (is_ext_slot) begin
            tgt_wait  = slot_wait_sel;
            tgt_rdata = slot_rdata;
        end else begin
            tgt_wait  = 1'b0;
            tgt_rdata = 8'hFF;
        end
    end

    assign mem_read    = bus_read  & ~is_slot_page & ~in_abort;
    assign mem_write   = bus_write & ~is_slot_page & ~in_abort;
    assign bus_wait    = strobe & tgt_wait & ~in_abort;
    assign bus_data_rx = in_abort ? 8'hFF : tgt_rdata;

    // --------------------------------------------------------------- timeout
    assign tmo_applicable = is_ext_slot | (~is_slot_page & (MEM_TIMEOUT_EN != 0));

    bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (strobe & tmo_applicable & ~in_abort),
        .wait_i   (tgt_wait),
        .done_i   (strobe & ~tgt_wait),
        .expire_o (expire)
    );

    // ------------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (expire)                  state_d = ST_ABORT;
                else if (strobe && tgt_wait) state_d = ST_ACTIVE;
                else                         state_d = ST_IDLE;
            end
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- status
    assign err_evt    = in_abort | (strobe & is_unmapped);
    assign status_clr = bus_write & is_status & ~in_abort
                      & (bus_address[3:0] == REG_STATUS);

    always_comb begin
        status_d   = status_q;
        err_addr_d = err_addr_q;
        if (status_clr) begin
            status_d = status_q & ~(bus_data_tx & STATUS_W1C_MASK);
        end
        // Applied after the clear so a new error wins over write-1-clear.
        if (pend_valid_q) begin
            if (status_q[STAT_DECODE_BIT:STAT_TIMEOUT_BIT] == 2'b00) begin
                err_addr_d = pend_addr_q;
            end else begin
                status_d[STAT_OVERFLOW_BIT] = 1'b1;
            end
            if (pend_timeout_q) status_d[STAT_TIMEOUT_BIT] = 1'b1;
            else                status_d[STAT_DECODE_BIT]  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every flop here has a defined reset value; there is no RAM to leave unreset.
            state_q        <= ST_IDLE;
            status_q       <= 8'h00;
            err_addr_q     <= 16'h0000;
            error_irq_q    <= 1'b0;
            pend_valid_q   <= 1'b0;
            pend_timeout_q <= 1'b0;
            pend_addr_q    <= 16'h0000;
        end else begin
            state_q        <= state_d;
            status_q       <= status_d;
            err_addr_q     <= err_addr_d;
            error_irq_q    <= status_d[STAT_TIMEOUT_BIT] | status_d[STAT_DECODE_BIT];
            pend_valid_q   <= err_evt;
            pend_timeout_q <= in_abort;
            pend_addr_q    <= bus_address;
        end
    end

    assign error_irq = error_irq_q;

endmodule

// File: tb/tb_periph_bus.sv
// -----------------------------------------------------------------------------
// tb_periph_bus
// Self-checking bench for periph_bus with NUM_SLOTS=4, TIMEOUT_CYCLES=8,
// MEM_TIMEOUT_EN=0. Single-cycle accesses come from a vector table through a
// scoreboard queue; stalls, timeout, error logging and reset are hand-written
// sequences. Inputs change just after the falling edge, outputs are sampled
// 1 ns later.
// -----------------------------------------------------------------------------
module tb_periph_bus;
    import periph_bus_pkg::*;

    localparam int NS  = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   bus_address;
    logic [7:0]    bus_data_tx;
    logic          bus_read, bus_write;
    logic [7:0]    bus_data_rx;
    logic          bus_wait;
    logic          mem_read, mem_write;
    logic [7:0]    mem_data_rx;
    logic          mem_wait;
    logic [3:0]    slot_address;
    logic [7:0]    slot_data_tx;
    logic [NS-1:0] slot_read, slot_write;
    logic [8*NS-1:0] slot_data_rx;
    logic [NS-1:0] slot_wait;
    logic          error_irq;

    periph_bus #(
        .NUM_SLOTS      (NS),
        .TIMEOUT_CYCLES (TMO),
        .MEM_TIMEOUT_EN (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_address  (bus_address),
        .bus_data_tx  (bus_data_tx),
        .bus_read     (bus_read),
        .bus_write    (bus_write),
        .bus_data_rx  (bus_data_rx),
        .bus_wait     (bus_wait),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_data_rx  (mem_data_rx),
        .mem_wait     (mem_wait),
        .slot_address (slot_address),
        .slot_data_tx (slot_data_tx),
        .slot_read    (slot_read),
        .slot_write   (slot_write),
        .slot_data_rx (slot_data_rx),
        .slot_wait    (slot_wait),
        .error_irq    (error_irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Observed outputs: {rx[7:0], wait, mem_rd, mem_wr, slot_rd[3:0], slot_wr[3:0]}
    function automatic logic [18:0] observe();
        return {bus_data_rx, bus_wait, mem_read, mem_write, slot_read, slot_write};
    endfunction

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rd;
        logic        wr;
        logic [3:0]  swait;
        logic        mwait;
        logic [7:0]  mdata;
        logic [18:0] exp;
    } vec_t;

    vec_t        vecs[15];
    logic [18:0] sb_q[$];

    task automatic step(input logic [15:0] addr, input logic [7:0] data, input logic rd,
                        input logic wr, input logic [3:0] swait, input logic mwait);
        @(negedge clk);
        bus_address = addr;
        bus_data_tx = data;
        bus_read    = rd;
        bus_write   = wr;
        slot_wait   = swait;
        mem_wait    = mwait;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(16'h0000, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic reg_read(input logic [15:0] addr, output logic [7:0] val);
        step(addr, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0);
        val = bus_data_rx;
    endtask

    logic [7:0] v;
    int         n;
    logic       bad_run;

    initial begin
        // Slot read data: slot0 B0, slot1 A5, slot2 C2, slot3 D3
        slot_data_rx = {8'hD3, 8'hC2, 8'hA5, 8'hB0};
        mem_data_rx  = 8'h00;
        bus_address  = 16'h0000;
        bus_data_tx  = 8'h00;
        bus_read     = 1'b0;
        bus_write    = 1'b0;
        slot_wait    = '0;
        mem_wait     = 1'b0;
        rst_n        = 1'b0;

        //                 addr      data   rd    wr    swait mwait mdata  {rx, w, mr, mw, srd, swr}
        vecs[0]  = '{16'h1234, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 8'h3C, {8'h3C, 3'b010, 4'h0, 4'h0}};
        vecs[1]  = '{16'h4000, 8'h5A, 1'b0, 1'b1, 4'h0, 1'b0, 8'h00, {8'h00, 3'b001, 4'h0, 4'h0}};
        vecs[2]  = '{16'hFF01, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, {8'hB0, 3'b000, 4'h1, 4'h0}};
        vecs[3]  = '{16'hFF25, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, {8'hC2, 3'b000, 4'h4, 4'h0}};
        vecs[4]  = '{16'hFF3E, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, {8'hD3, 3'b000, 4'h8, 4'h0}};
        vecs[5]  = '{16'hFF10, 8'h77, 1'b0, 1'b1, 4'h0, 1'b0, 8'h00, {8'hA5, 3'b000, 4'h0, 4'h2}};
        vecs[6]  = '{16'hFFF3, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, {8'h04, 3'b000, 4'h0, 4'h0}};
        vecs[7]  = '{16'hFFF5, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, {8'h00, 3'b000, 4'h0, 4'h0}};
        vecs[8]  = '{16'hFFF1, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, {8'h00, 3'b000, 4'h0, 4'h0}};
        vecs[9]  = '{16'h2000, 8'h00, 1'b1, 1'b0, 4'h0, 1'b1, 8'h11, {8'h11, 3'b110, 4'h0, 4'h0}};
        vecs[10] = '{16'h2000, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 8'h11, {8'h11, 3'b010, 4'h0, 4'h0}};
        vecs[11] = '{16'hFF20, 8'h00, 1'b1, 1'b0, 4'h4, 1'b0, 8'h00, {8'hC2, 3'b100, 4'h4, 4'h0}};
        vecs[12] = '{16'hFF20, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, {8'hC2, 3'b000, 4'h4, 4'h0}};
        vecs[13] = '{16'hFF02, 8'h00, 1'b1, 1'b0, 4'h2, 1'b0, 8'h00, {8'hB0, 3'b000, 4'h1, 4'h0}};
        vecs[14] = '{16'hFFF0, 8'h00, 1'b1, 1'b0, 4'hF, 1'b0, 8'h00, {8'h00, 3'b000, 4'h0, 4'h0}};

        // ---- reset state
        #12;
        check("rst_state", dut.state_q, ST_IDLE);
        check("rst_irq", error_irq, 1'b0);
        rst_n = 1'b1;
        reg_read(16'hFFF0, v); check("rst_status", v, 8'h00);
        reg_read(16'hFFF1, v); check("rst_err_lo", v, 8'h00);
        reg_read(16'hFFF2, v); check("rst_err_hi", v, 8'h00);

        // ---- table of single-cycle accesses through the scoreboard
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus_address = vecs[i].addr;
            bus_data_tx = vecs[i].data;
            bus_read    = vecs[i].rd;
            bus_write   = vecs[i].wr;
            slot_wait   = vecs[i].swait;
            mem_wait    = vecs[i].mwait;
            mem_data_rx = vecs[i].mdata;
            sb_q.push_back(vecs[i].exp);
            #1;
            check($sformatf("vec%0d", i), observe(), sb_q.pop_front());
            check($sformatf("vec%0d_slotbus", i), {slot_address, slot_data_tx},
                  {vecs[i].addr[3:0], vecs[i].data});
        end
        idle(2);

        // ---- slot 1 read with 3 wait cycles
        for (int k = 0; k < 3; k++) begin
            step(16'hFF12, 8'h00, 1'b1, 1'b0, 4'h2, 1'b0);
            check($sformatf("s1_wait%0d", k), bus_wait, 1'b1);
        end
        step(16'hFF12, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0);
        check("s1_done_wait", bus_wait, 1'b0);
        check("s1_done_data", bus_data_rx, 8'hA5);
        idle(2);
        reg_read(16'hFFF0, v); check("s1_status", v, 8'h00);

        // ---- wait drops on the cycle the count reaches TIMEOUT: normal completion
        for (int k = 0; k < TMO - 1; k++) step(16'hFF03, 8'h00, 1'b1, 1'b0, 4'h1, 1'b0);
        step(16'hFF03, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0);
        check("prio_obs", observe(), {8'hB0, 3'b000, 4'h1, 4'h0});
        idle(1);
        check("prio_state", dut.state_q, ST_IDLE);
        idle(1);
        reg_read(16'hFFF0, v); check("prio_status", v, 8'h00);

        // ---- unmapped write then unmapped read
        step(16'hFF70, 8'h99, 1'b0, 1'b1, 4'h0, 1'b0);
        check("unm_wr_obs", observe(), {8'hFF, 3'b000, 4'h0, 4'h0});
        idle(2);
        reg_read(16'hFFF0, v); check("unm_status1", v, 8'h02);
        reg_read(16'hFFF1, v); check("unm_err_lo1", v, 8'h70);
        reg_read(16'hFFF2, v); check("unm_err_hi1", v, 8'hFF);
        step(16'hFF80, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0);
        check("unm_rd_obs", observe(), {8'hFF, 3'b000, 4'h0, 4'h0});
        idle(2);
        reg_read(16'hFFF0, v); check("unm_status2", v, 8'h82);
        reg_read(16'hFFF1, v); check("unm_err_lo2", v, 8'h70);
        check("unm_irq", error_irq, 1'b1);

        // ---- write-1-clear everything
        step(16'hFFF0, 8'hFF, 1'b0, 1'b1, 4'h0, 1'b0);
        idle(2);
        reg_read(16'hFFF0, v); check("clr_status", v, 8'h00);
        check("clr_irq", error_irq, 1'b0);

        // ---- timeout on slot 0 with wait stuck high
        step(16'hFF03, 8'h00, 1'b1, 1'b0, 4'h1, 1'b0);
        n = 0;
        while (bus_wait && n < 40) begin
            n++;
            step(16'hFF03, 8'h00, 1'b1, 1'b0, 4'h1, 1'b0);
        end
        check("tmo_wait_cycles", n, TMO);
        check("tmo_abort_obs", observe(), {8'hFF, 3'b000, 4'h0, 4'h0});
        check("tmo_abort_state", dut.state_q, ST_ABORT);
        idle(1);
        check("tmo_back_idle", dut.state_q, ST_IDLE);
        idle(1);
        reg_read(16'hFFF0, v); check("tmo_status", v, 8'h01);
        reg_read(16'hFFF1, v); check("tmo_err_lo", v, 8'h03);
        reg_read(16'hFFF2, v); check("tmo_err_hi", v, 8'hFF);
        check("tmo_irq", error_irq, 1'b1);

        // ---- decode error meets a write-1-clear of both low bits
        step(16'hFF80, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0);
        step(16'hFFF0, 8'h03, 1'b0, 1'b1, 4'h0, 1'b0);
        check("race_irq0", error_irq, 1'b1);
        idle(1);
        check("race_irq1", error_irq, 1'b1);
        reg_read(16'hFFF0, v); check("race_low_bits", v & 8'h03, 8'h02);
        check("race_irq2", error_irq, 1'b1);

        // ---- long memory stall, no timeout; asynchronous reset mid-access
        bad_run = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            step(16'h8000, 8'h00, 1'b1, 1'b0, 4'h0, 1'b1);
            if (!bus_wait || dut.state_q == ST_ABORT) bad_run = 1'b1;
            if (c == 500) begin
                check("mem_state_pre", dut.state_q, ST_ACTIVE);
                rst_n = 1'b0;
                #1;
                check("mem_rst_state", dut.state_q, ST_IDLE);
                check("mem_rst_count", dut.u_timeout.count_q, 0);
                check("mem_rst_irq", error_irq, 1'b0);
                check("mem_rst_wait", bus_wait, 1'b1);
                #1;
                rst_n = 1'b1;
            end
        end
        check("mem_no_abort", bad_run, 1'b0);
        step(16'h8000, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0);
        check("mem_done_wait", bus_wait, 1'b0);
        idle(2);
        reg_read(16'hFFF0, v); check("mem_status", v, 8'h00);
        reg_read(16'hFFF1, v); check("mem_err_lo", v, 8'h00);
        reg_read(16'hFFF2, v); check("mem_err_hi", v, 8'h00);
        check("mem_irq", error_irq, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
